cba_shared_add_scheduler: RTL and testbench

Shares one 4-bit carry_bypass_adder slice between two requesters. Each granted request is a WIDTH-bit add, run serially one nibble per cycle, least significant nibble first, with the carry registered between slices. Round-robin arbitration is done in IDLE. Results return on one valid/ready response channel tagged with the requester id. The block sits between operand producers and a consumer wherever area matters more than add latency.

---
 rtl/cba_shared_add_scheduler.sv | 162 ++++++++++++++++
 tb/tb_cba_shared_add_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cba_shared_add_scheduler.sv
// Two-requester scheduler time-sharing one 4-bit carry-bypass adder slice.
// Each granted WIDTH-bit add runs one nibble per cycle, LSB nibble first.

module carry_bypass_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out,
    output logic       bypass
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_chain
        assign c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign sum    = p ^ c[3:0];
    // All-propagate slice: carry skips straight from c_in to c_out
    assign bypass = &p;
    assign c_out  = bypass ? c_in : c[4];
endmodule

module cba_shared_add_scheduler #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH / 4 + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic [CNTW-1:0]  rsp_bypass_cnt
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } add_req_t;

    state_t                  state_q, state_d;
    add_req_t [1:0]          req;
    add_req_t                sel;
    logic [1:0]              req_vld;
    logic [1:0]              req_rdy;
    logic                    grant_id;
    logic                    accept;
    logic                    rsp_fire;
    logic                    ptr_q;

    logic [NSLICE-1:0][3:0]  a_q, b_q, sum_q;
    logic                    id_q;
    logic                    carry_q;
    logic [IDXW-1:0]         idx_q;
    logic [CNTW-1:0]         cnt_q;
    logic                    last_slice;

    logic [3:0]              slice_sum;
    logic                    slice_cout;
    logic                    slice_byp;

    assign req[0]  = {req0_a, req0_b, req0_cin};
    assign req[1]  = {req1_a, req1_b, req1_cin};
    assign req_vld = {req1_valid, req0_valid};

    // Pointer only matters on a tie; a lone requester always wins
    assign grant_id   = (req_vld == 2'b11) ? ptr_q : req_vld[1];
    assign sel        = req[grant_id];
    assign last_slice = (idx_q == IDXW'(NSLICE - 1));
    assign rsp_valid  = (state_q == DONE);
    assign rsp_fire   = rsp_valid & rsp_ready;

    carry_bypass_adder u_slice (
        .a      (a_q[idx_q]),
        .b      (b_q[idx_q]),
        .c_in   (carry_q),
        .sum    (slice_sum),
        .c_out  (slice_cout),
        .bypass (slice_byp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        req_rdy = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_vld) begin
                    req_rdy[grant_id] = 1'b1;
                    accept            = 1'b1;
                    state_d           = RUN;
                end
            end
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (rsp_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= sel.a;
                b_q     <= sel.b;
                id_q    <= grant_id;
                carry_q <= sel.cin;
                idx_q   <= '0;
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                sum_q[idx_q] <= slice_sum;
                carry_q      <= slice_cout;
                idx_q        <= idx_q + IDXW'(1);
                if (slice_byp) cnt_q <= cnt_q + CNTW'(1);
            end
            if (rsp_fire) ptr_q <= ~id_q;
        end
    end

    assign req0_ready     = req_rdy[0];
    assign req1_ready     = req_rdy[1];
    assign rsp_sum        = sum_q;
    assign rsp_cout       = carry_q;
    assign rsp_id         = id_q;
    assign rsp_bypass_cnt = cnt_q;
endmodule

// File: tb/tb_cba_shared_add_scheduler.sv
// Scoreboard bench for cba_shared_add_scheduler (WIDTH=16, directed vectors).

module tb_cba_shared_add_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_cin, req1_cin;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
    logic [15:0] rsp_sum;
    logic [2:0]  rsp_bypass_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic [2:0]  cnt;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        id;
        logic [2:0]  cnt;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];

    cba_shared_add_scheduler #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .rsp_id(rsp_id), .rsp_bypass_cnt(rsp_bypass_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Hand-computed: {a, b, cin, sum, cout, bypassed nibble count}
    function automatic vec_t get_vec(input int v);
        case (v)
            0:       return {16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd3};
            1:       return {16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 3'd0};
            2:       return {16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 3'd4};
            3:       return {16'h00F0, 16'h0F0F, 1'b0, 16'h0FFF, 1'b0, 3'd3};
            4:       return {16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 3'd0};
            5:       return {16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 3'd0};
            6:       return {16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 3'd4};
            default: return {16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 3'd2};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic do_req(input int id, input int v);
        vec_t vec = get_vec(v);
        exp_t e;
        int   n   = 0;
        bit   acc = 0;
        @(negedge clk);
        if (id == 0) begin req0_valid = 1; req0_a = vec.a; req0_b = vec.b; req0_cin = vec.cin; end
        else         begin req1_valid = 1; req1_a = vec.a; req1_b = vec.b; req1_cin = vec.cin; end
        #1;
        while (!acc && n < 200) begin
            if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
                acc = 1;
                @(posedge clk);
                #1;
                e.sum = vec.sum; e.cout = vec.cout; e.id = id[0]; e.cnt = vec.cnt; e.acc = cyc;
                exp_q.push_back(e);
                grant_log.push_back(id);
            end else begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        if (id == 0) begin req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0; end
        else         begin req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0; end
        if (!acc) chk("accept_timeout", 32'(id), 32'hDEAD);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    // Monitor: pops on every response handshake, checks hold-stability under backpressure
    bit          vprev   = 0;
    bit          stalled = 0;
    logic [22:0] snap;

    always @(negedge clk) begin
        logic [22:0] cur;
        exp_t        e;
        cur = {rsp_sum, rsp_cout, rsp_id, rsp_bypass_cnt};
        if (!rst_n) begin
            vprev   = 0;
            stalled = 0;
        end else begin
            if (rsp_valid) chk("ready_outside_idle", {30'd0, req1_ready, req0_ready}, 0);
            if (rsp_valid && stalled) chk("rsp_stable", 32'(cur), 32'(snap));
            if (rsp_valid && !vprev && exp_q.size() > 0) chk("latency", 32'(cyc - exp_q[0].acc), 4);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_sum), 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                    chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_bypass_cnt", 32'(rsp_bypass_cnt), 32'(e.cnt));
                end
                stalled = 0;
            end else if (rsp_valid) begin
                stalled = 1;
                snap    = cur;
            end
            vprev = rsp_valid;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_sum"},   32'(rsp_sum), 0);
        chk({tag, "_cout"},  32'(rsp_cout), 0);
        chk({tag, "_id"},    32'(rsp_id), 0);
        chk({tag, "_cnt"},   32'(rsp_bypass_cnt), 0);
        chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 0; rsp_ready = 1;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("por");
        @(negedge clk) rst_n = 1;

        // Both requesters stay busy: grants must alternate starting with req0
        grant_log.delete();
        fork
            begin do_req(0, 3); do_req(0, 4); end
            begin do_req(1, 5); do_req(1, 6); end
        join
        drain();
        chk("alt_count", 32'(grant_log.size()), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("alt_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));

        // Backpressure: hold rsp_ready low for 5 cycles in DONE
        rsp_ready = 0;
        fork
            do_req(0, 7);
            begin repeat (2) @(negedge clk); do_req(1, 4); end
            begin
                n = 0;
                while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
                chk("bp_valid_seen", 32'(rsp_valid), 1);
                repeat (5) @(negedge clk);
                @(posedge clk);
                #2 rsp_ready = 1;
                @(posedge clk);
                #1 chk("bp_done_one_cycle", 32'(rsp_valid), 0);
            end
        join
        drain();

        // Directed vectors from the plan
        do_req(0, 0); drain();
        do_req(1, 1); drain();
        do_req(0, 2); drain();

        // Reset in RUN at slice index 2; the op is dropped and priority returns to req0
        do_req(1, 5);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 0;
        exp_q.delete();
        #1 chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (6) @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_valid), 0);
        grant_log.delete();
        fork
            do_req(1, 6);
            do_req(0, 7);
        join
        drain();
        chk("post_rst_count", 32'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            chk("post_rst_first", 32'(grant_log[0]), 0);
            chk("post_rst_second", 32'(grant_log[1]), 1);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
